// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider plus horizontal/vertical counters producing VGA sync, blanking and frame markers.
module vga_timing_gen #(
    parameter int DIV       = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [3:0] DIV_MAX  = 4'(DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [3:0] divider;
    logic [9:0] x_next, y_next;

    assign p_tick      = divider == DIV_MAX;
    assign video_on    = pix_x < H_VIS && pix_y < V_VIS;
    assign frame_start = p_tick && pix_x == '0 && pix_y == '0;

    always_comb begin
        x_next = p_tick ? (pix_x == H_MAX ? '0 : pix_x + 10'd1) : pix_x;
        y_next = (p_tick && pix_x == H_MAX) ? (pix_y == V_MAX ? '0 : pix_y + 10'd1) : pix_y;
    end

    // syncs are decoded from the next counts so they register on the same edge as the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= '0;
            pix_x   <= '0;
            pix_y   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            divider <= p_tick ? '0 : divider + 4'd1;
            pix_x   <= x_next;
            pix_y   <= y_next;
            hsync   <= !(x_next >= HS_FIRST && x_next <= HS_LAST);
            vsync   <= !(y_next >= VS_FIRST && y_next <= VS_LAST);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of three timing generator instances against a closed-form timing model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic a_hs, a_vs, a_vo, a_pt, a_fs;
    logic b_hs, b_vs, b_vo, b_pt, b_fs;
    logic c_hs, c_vs, c_vo, c_pt, c_fs;
    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;

    int tests = 0;
    int fails = 0;
    int k = 0;

    typedef struct packed {
        logic pt, hs, vs, vo, fs;
        logic [9:0] x, y;
    } exp_t;

    vga_timing_gen u_def4 (
        .clk(clk), .reset_n(reset_n), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
        .p_tick(a_pt), .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small4 (
        .clk(clk), .reset_n(reset_n), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
        .p_tick(b_pt), .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs)
    );

    vga_timing_gen #(.DIV(2)) u_def2 (
        .clk(clk), .reset_n(reset_n), .hsync(c_hs), .vsync(c_vs), .video_on(c_vo),
        .p_tick(c_pt), .pix_x(c_x), .pix_y(c_y), .frame_start(c_fs)
    );

    // expected outputs after kk rising edges since reset release
    function automatic exp_t model(input int kk, input int div, input int hd, input int hf, input int hs,
                                   input int hb, input int vd, input int vf, input int vs, input int vb);
        exp_t e;
        int n, ht, x, y;
        ht = hd + hf + hs + hb;
        n = kk / div;
        x = n % ht;
        y = (n / ht) % (vd + vf + vs + vb);
        e.pt = (kk % div) == div - 1;
        e.x = 10'(x);
        e.y = 10'(y);
        e.hs = !(x >= hd + hf && x < hd + hf + hs);
        e.vs = !(y >= vd + vf && y < vd + vf + vs);
        e.vo = x < hd && y < vd;
        e.fs = e.pt && x == 0 && y == 0;
        return e;
    endfunction

    task automatic check(input string tag, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic cmp(input string who, input exp_t e, input logic pt, input logic hs, input logic vs,
                       input logic vo, input logic fs, input logic [9:0] x, input logic [9:0] y);
        check($sformatf("%s k=%0d p_tick", who, k), int'(pt), int'(e.pt));
        check($sformatf("%s k=%0d hsync", who, k), int'(hs), int'(e.hs));
        check($sformatf("%s k=%0d vsync", who, k), int'(vs), int'(e.vs));
        check($sformatf("%s k=%0d video_on", who, k), int'(vo), int'(e.vo));
        check($sformatf("%s k=%0d frame_start", who, k), int'(fs), int'(e.fs));
        check($sformatf("%s k=%0d pix_x", who, k), int'(x), int'(e.x));
        check($sformatf("%s k=%0d pix_y", who, k), int'(y), int'(e.y));
    endtask

    task automatic check_all();
        cmp("def4", model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33), a_pt, a_hs, a_vs, a_vo, a_fs, a_x, a_y);
        cmp("small4", model(k, 4, 8, 2, 3, 3, 4, 2, 2, 2), b_pt, b_hs, b_vs, b_vo, b_fs, b_x, b_y);
        cmp("def2", model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33), c_pt, c_hs, c_vs, c_vo, c_fs, c_x, c_y);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
        check_all();
    endtask

    int a_hs_low = 0, a_vo_low = 0, b_vs_low = 0, a_fs_n = 0, c_fs_n = 0, b_last = -1;

    initial begin
        #1 reset_n = 1'b0;
        #1 check_all();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3400; i++) begin
            step();
            if (k < 3200 && !a_hs) a_hs_low++;
            if (k < 3200 && !a_vo) a_vo_low++;
            if (k < 640 && !b_vs) b_vs_low++;
            if (a_fs) a_fs_n++;
            if (c_fs) c_fs_n++;
            if (b_fs) begin
                if (b_last >= 0) check("small4 frame period", k - b_last, 640);
                b_last = k;
            end
        end
        check("def4 hsync low clks", a_hs_low, 384);
        check("def4 video_on low clks in line", a_vo_low, 640);
        check("small4 vsync low clks", b_vs_low, 128);
        check("def4 frame_start count", a_fs_n, 1);
        check("def2 frame_start count", c_fs_n, 1);

        reset_n = 1'b0;
        #2 k = 0;
        check_all();
        reset_n = 1'b1;
        for (int i = 0; i < 429; i++) step();
        check("small4 hsync in window", int'(b_hs), 0);
        check("small4 vsync in window", int'(b_vs), 0);
        check("small4 pix_x before reset", int'(b_x), 11);
        check("small4 pix_y before reset", int'(b_y), 6);
        #2 reset_n = 1'b0;
        #1 k = 0;
        check("small4 async hsync", int'(b_hs), 1);
        check("small4 async vsync", int'(b_vs), 1);
        check("small4 async pix_x", int'(b_x), 0);
        check("small4 async pix_y", int'(b_y), 0);
        check_all();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4: system clocks per pixel, legal range 2..16.
REQ-002 Parameter H_DISPLAY / H_FRONT / H_SYNC / H_BACK, defaults 640 / 16 / 96 / 48: horizontal timing in pixels.
REQ-003 Parameter V_DISPLAY / V_FRONT / V_SYNC / V_BACK, defaults 480 / 10 / 2 / 33: vertical timing in lines.
REQ-004 clk  input  1  system clock (100 MHz nominal); sole clock, all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 hsync  output  1  horizontal sync, low during the sync pulse.
REQ-007 vsync  output  1  vertical sync, low during the sync pulse.
REQ-008 video_on  output  1  high while the current pixel is in the visible area.
REQ-009 p_tick  output  1  one-clk pulse marking each pixel-clock advance.
REQ-010 pix_x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-011 pix_y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-012 frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-013 H_TOTAL = sum of horizontal parameters (800); V_TOTAL = sum of vertical parameters (525).
REQ-014 Divider: 4-bit counter, counts 0..DIV-1 and wraps to 0; p_tick = 1 exactly when divider == DIV-1.
REQ-015 pix_x increments only in cycles with p_tick = 1; at H_TOTAL-1 it wraps to 0.
REQ-016 pix_y increments only when p_tick = 1 and pix_x == H_TOTAL-1; at V_TOTAL-1 it wraps to 0 in the same cycle pix_x wraps.
REQ-017 hsync and vsync are registers computed from the next counter values, so they update on the same edge as pix_x/pix_y and match the displayed count with zero skew.
REQ-018 hsync = 0 iff pix_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751]; otherwise 1.
REQ-019 vsync = 0 iff pix_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491]; otherwise 1.
REQ-020 video_on = (pix_x < H_DISPLAY) and (pix_y < V_DISPLAY); decoded from registered counters; no glitches between edges.
REQ-021 frame_start = p_tick and pix_x == 0 and pix_y == 0: exactly one clk per frame.
REQ-022 Counters never take values outside 0..H_TOTAL-1 / 0..V_TOTAL-1; no state beyond divider, pix_x, pix_y, hsync, vsync.
REQ-023 Line period is H_TOTAL*DIV clks (3200); frame period is H_TOTAL*V_TOTAL*DIV clks (1,680,000).

Reset
REQ-024 reset_n = 0 forces immediately, independent of clk: divider 0, pix_x 0, pix_y 0, hsync 1, vsync 1; hence p_tick 0, frame_start 0, video_on 1.
REQ-025 Reset asserted mid-frame abandons the frame; after release, the first p_tick occurs on the DIV-th rising edge and coincides with frame_start.
REQ-026 No output toggles while reset_n is held low.

Verification
REQ-027 Release reset, run 40 clks -> p_tick high on clks 4, 8, 12, ... (one clk wide); pix_x = 1 after the first p_tick edge; frame_start high only at the first p_tick.
REQ-028 Run one full line -> hsync falls when pix_x becomes 656, rises when pix_x becomes 752; low for 96*4 = 384 clks; video_on falls when pix_x becomes 640.
REQ-029 Run one full frame -> vsync low exactly while pix_y in 490..491 (2*3200 = 6400 clks); video_on low for all pix_y >= 480; pix_x/pix_y wrap 799->0 and 524->0 on the same edge.
REQ-030 Count clks between successive frame_start pulses -> exactly 1,680,000; exactly one pulse per frame.
REQ-031 Assert reset_n low at pix_x = 700, pix_y = 490 (hsync and vsync both low), between clk edges -> both sync outputs high and counters 0 immediately; after release, timing restarts per REQ-025.
REQ-032 Instantiate with DIV = 2 -> p_tick every 2 clks; frame period 840,000 clks; sync windows unchanged in pixel units.
